// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter: grants one master at a time to its target slave,
// with a one-cycle turnaround after every grant and a per-grant BUSY timeout.
module bus_arbiter #(
  parameter int unsigned NO_MASTERS = 2,
  parameter int unsigned NO_SLAVES  = 3,
  parameter int unsigned S_ID_WIDTH = $clog2(NO_SLAVES + 1),
  parameter int unsigned M_ID_WIDTH = $clog2(NO_MASTERS),
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                             clk,
  input  logic                             rstN,
  input  logic [NO_MASTERS-1:0]            req,
  input  logic [NO_MASTERS*S_ID_WIDTH-1:0] slave_id,
  input  logic [NO_MASTERS-1:0]            done,
  output logic [NO_MASTERS-1:0]            grant,
  output logic [M_ID_WIDTH-1:0]            master_sel,
  output logic [S_ID_WIDTH-1:0]            slave_sel,
  output logic                             bus_busy,
  output logic                             timeout_err
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT);
  localparam logic [M_ID_WIDTH-1:0] TOP_MASTER = M_ID_WIDTH'(NO_MASTERS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t                  state;
  logic [M_ID_WIDTH-1:0]   last_granted;
  logic [CNT_W-1:0]        busy_cnt;

  logic [S_ID_WIDTH-1:0]   sid [NO_MASTERS];
  logic [NO_MASTERS-1:0]   valid;
  logic                    win_found;
  logic [M_ID_WIDTH-1:0]   win_idx;
  logic [M_ID_WIDTH-1:0]   scan;

  // A request counts only when it targets an existing slave.
  for (genvar m = 0; m < NO_MASTERS; m++) begin : g_valid
    assign sid[m]   = slave_id[m*S_ID_WIDTH +: S_ID_WIDTH];
    assign valid[m] = req[m] && (sid[m] != '0) && (32'(sid[m]) <= NO_SLAVES);
  end

  // Round-robin search starting just after the last granted master.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_granted;
    scan      = last_granted;
    for (int unsigned i = 0; i < NO_MASTERS; i++) begin
      scan = (scan == TOP_MASTER) ? '0 : scan + 1'b1;
      if (!win_found && valid[scan]) begin
        win_found = 1'b1;
        win_idx   = scan;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state        <= IDLE;
      last_granted <= TOP_MASTER;
      busy_cnt     <= '0;
      grant        <= '0;
      master_sel   <= '0;
      slave_sel    <= '0;
      bus_busy     <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            state        <= BUSY;
            last_granted <= win_idx;
            busy_cnt     <= '0;
            grant        <= NO_MASTERS'(1) << win_idx;
            master_sel   <= win_idx;
            slave_sel    <= sid[win_idx];
            bus_busy     <= 1'b1;
          end
        end
        BUSY: begin
          busy_cnt <= (busy_cnt == CNT_SAT) ? busy_cnt : busy_cnt + 1'b1;
          // Completion by the owner takes priority over a coincident timeout.
          if (done[master_sel] || !req[master_sel]) begin
            state     <= RELEASE;
            grant     <= '0;
            slave_sel <= '0;
          end else if (busy_cnt >= CNT_LAST) begin
            state       <= RELEASE;
            grant       <= '0;
            slave_sel   <= '0;
            timeout_err <= 1'b1;
          end
        end
        RELEASE: begin
          state    <= IDLE;
          bus_busy <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          grant     <= '0;
          slave_sel <= '0;
          bus_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized
// traffic compared every cycle against a transaction-level reference model.
module tb_bus_arbiter;

  localparam int NM   = 2;
  localparam int NS   = 3;
  localparam int SW   = 2;
  localparam int MW   = 1;
  localparam int TO   = 4;
  localparam int SIDW = NM * SW;

  logic            clk = 1'b0;
  logic            rstN;
  logic [NM-1:0]   req;
  logic [SIDW-1:0] slave_id;
  logic [NM-1:0]   done;
  logic [NM-1:0]   grant;
  logic [MW-1:0]   master_sel;
  logic [SW-1:0]   slave_sel;
  logic            bus_busy;
  logic            timeout_err;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Reference model: 0 = idle, 1 = owner holds the bus, 2 = turnaround
  int m_state  = 0;
  int m_owner  = 0;
  int m_sid    = 0;
  int m_cycles = 0;
  int m_last   = NM - 1;
  bit m_terr   = 1'b0;

  bus_arbiter #(
    .NO_MASTERS(NM),
    .NO_SLAVES (NS),
    .TIMEOUT   (TO)
  ) dut (
    .clk        (clk),
    .rstN       (rstN),
    .req        (req),
    .slave_id   (slave_id),
    .done       (done),
    .grant      (grant),
    .master_sel (master_sel),
    .slave_sel  (slave_sel),
    .bus_busy   (bus_busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sid_of(input int m);
    return int'(slave_id[m*SW +: SW]);
  endfunction

  function automatic bit req_ok(input int m);
    return req[m] && (sid_of(m) >= 1) && (sid_of(m) <= NS);
  endfunction

  // Model advances on the same edge the design samples its inputs.
  always @(posedge clk) begin
    if (!rstN) begin
      m_state  = 0;
      m_owner  = 0;
      m_sid    = 0;
      m_cycles = 0;
      m_last   = NM - 1;
      m_terr   = 1'b0;
    end else begin
      m_terr = 1'b0;
      if (m_state == 0) begin
        for (int k = 1; k <= NM; k++) begin
          if (m_state == 0 && req_ok((m_last + k) % NM)) begin
            m_state  = 1;
            m_owner  = (m_last + k) % NM;
            m_sid    = sid_of(m_owner);
            m_last   = m_owner;
            m_cycles = 1;
          end
        end
      end else if (m_state == 1) begin
        if (done[m_owner] || !req[m_owner]) begin
          m_state = 2;
        end else if (m_cycles >= TO) begin
          m_state = 2;
          m_terr  = 1'b1;
        end else begin
          m_cycles++;
        end
      end else begin
        m_state = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("grant",       int'(grant),       (m_state == 1) ? (1 << m_owner) : 0);
      check("master_sel",  int'(master_sel),  m_owner);
      check("slave_sel",   int'(slave_sel),   (m_state == 1) ? m_sid : 0);
      check("bus_busy",    int'(bus_busy),    (m_state != 0) ? 1 : 0);
      check("timeout_err", int'(timeout_err), int'(m_terr));
      check("grant_onehot", int'($countones(grant) <= 1), 1);
      check("slave_without_grant", int'((slave_sel != '0) && (grant == '0)), 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input int budget);
    int t = 0;
    while (grant == '0 && t < budget) begin
      tick();
      t++;
    end
    check("grant_wait", int'(grant != '0), 1);
  endtask

  initial begin
    bit seen0;
    bit seen1;
    int exp_m [3] = '{0, 1, 0};

    rstN = 1'b0; req = '0; slave_id = '0; done = '0;
    tick(); tick();
    chk_en = 1'b1;
    check("rst_grant", int'(grant), 0);
    check("rst_msel",  int'(master_sel), 0);
    check("rst_ssel",  int'(slave_sel), 0);
    check("rst_busy",  int'(bus_busy), 0);
    check("rst_terr",  int'(timeout_err), 0);

    // First grant after reset goes to master 0 with a one-cycle latency
    rstN = 1'b1; req = 2'b01; slave_id = {2'd0, 2'd2};
    tick();
    check("first_grant", int'(grant), 1);
    check("first_msel",  int'(master_sel), 0);
    check("first_ssel",  int'(slave_sel), 2);
    check("first_busy",  int'(bus_busy), 1);
    req = 2'b00;
    tick();
    check("drop_rel_grant", int'(grant), 0);
    check("drop_rel_ssel",  int'(slave_sel), 0);
    check("drop_rel_busy",  int'(bus_busy), 1);
    tick();
    check("drop_idle_busy", int'(bus_busy), 0);

    // Alternating grants with done three cycles into each grant
    rstN = 1'b0; tick(); rstN = 1'b1;
    req = 2'b11; slave_id = {2'd3, 2'd1};
    for (int i = 0; i < 3; i++) begin
      wait_grant(6);
      check("alt_grant", int'(grant), 1 << exp_m[i]);
      tick(); tick();
      done = NM'(1 << exp_m[i]);
      tick();
      check("alt_rel_grant", int'(grant), 0);
      check("alt_rel_ssel",  int'(slave_sel), 0);
      check("alt_rel_busy",  int'(bus_busy), 1);
      done = '0;
    end

    // Master 1 never completes: forced release after TO busy cycles
    req = 2'b10;
    wait_grant(6);
    check("to_grant", int'(grant), 2);
    check("to_ssel",  int'(slave_sel), 3);
    tick(); tick(); tick();
    check("to_last_busy_grant", int'(grant), 2);
    tick();
    check("to_rel_terr",  int'(timeout_err), 1);
    check("to_rel_grant", int'(grant), 0);
    check("to_rel_busy",  int'(bus_busy), 1);
    req = 2'b00;
    tick();
    check("to_idle_terr", int'(timeout_err), 0);
    check("to_idle_busy", int'(bus_busy), 0);

    // Master 0 targets slave 0: never eligible
    req = 2'b11; slave_id = {2'd3, 2'd0};
    seen0 = 1'b0; seen1 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (grant[0]) seen0 = 1'b1;
      if (grant == 2'b10 && slave_sel == 2'd3) seen1 = 1'b1;
    end
    check("invalid_never_granted", int'(seen0), 0);
    check("valid_granted_slave3",  int'(seen1), 1);
    req = 2'b00;
    tick(); tick(); tick();

    // Reset in the middle of a grant drops it immediately
    req = 2'b01; slave_id = {2'd3, 2'd1};
    wait_grant(6);
    tick();
    rstN = 1'b0;
    tick();
    check("midrst_grant", int'(grant), 0);
    check("midrst_ssel",  int'(slave_sel), 0);
    check("midrst_busy",  int'(bus_busy), 0);
    check("midrst_terr",  int'(timeout_err), 0);
    rstN = 1'b1;
    wait_grant(4);
    check("postrst_grant", int'(grant), 1);
    tick(); tick(); tick();
    done = 2'b01;
    tick();
    check("done_vs_to_terr",  int'(timeout_err), 0);
    check("done_vs_to_grant", int'(grant), 0);
    check("done_vs_to_busy",  int'(bus_busy), 1);
    done = '0; req = '0;
    tick(); tick();

    // Randomized traffic, checked every cycle against the model
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < NM; b++) begin
        if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
        done[b] = ($urandom_range(0, 5) == 0);
      end
      if ($urandom_range(0, 3) == 0) slave_id = SIDW'($urandom);
      rstN = ($urandom_range(0, 299) != 0);
      tick();
    end

    rstN = 1'b1; req = '0; done = '0;
    tick(); tick(); tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter NO_MASTERS, default 2, number of requesting masters.
REQ-002 SHALL have parameter NO_SLAVES, default 3, number of slaves; slave IDs 1..NO_SLAVES, ID 0 = no slave.
REQ-003 SHALL have parameter S_ID_WIDTH, default $clog2(NO_SLAVES+1), slave ID width.
REQ-004 SHALL have parameter M_ID_WIDTH, default $clog2(NO_MASTERS), master index width.
REQ-005 SHALL have parameter TIMEOUT, default 255, maximum BUSY cycles per grant (1..2^16-1).
REQ-006 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-007 SHALL have port rstN, input, 1, synchronous active-low reset.
REQ-008 SHALL have port req, input, NO_MASTERS, level request per master.
REQ-009 SHALL have port slave_id, input, NO_MASTERS*S_ID_WIDTH, target slave per master; master m uses bits [m*S_ID_WIDTH +: S_ID_WIDTH].
REQ-010 SHALL have port done, input, NO_MASTERS, transfer-complete pulse per master.
REQ-011 SHALL have port grant, output, NO_MASTERS, one-hot (or zero) grant.
REQ-012 SHALL have port master_sel, output, M_ID_WIDTH, master index for the master-to-slave bus mux.
REQ-013 SHALL have port slave_sel, output, S_ID_WIDTH, slave ID for the bus mux; 0 when bus not connected.
REQ-014 SHALL have port bus_busy, output, 1, high in BUSY and RELEASE.
REQ-015 SHALL have port timeout_err, output, 1, one-cycle pulse on forced release.

Function
REQ-016 SHALL implement states IDLE, BUSY, RELEASE; all outputs registered.
REQ-017 SHALL treat a request as valid only if req[m]=1 and 1 <= slave_id[m] <= NO_SLAVES; invalid requests are ignored and never granted.
REQ-018 In IDLE with any valid request at edge N, SHALL select winner round-robin, searching from (last_granted+1) mod NO_MASTERS upward, and enter BUSY at edge N.
REQ-019 In the cycle after edge N SHALL drive grant[winner]=1, master_sel=winner, slave_sel=slave_id[winner] (latched at N), bus_busy=1 (grant latency 1 cycle).
REQ-020 SHALL update last_granted to winner on entry to BUSY; last_granted resets to NO_MASTERS-1 so master 0 wins first.
REQ-021 master_sel and slave_sel SHALL stay constant throughout BUSY regardless of slave_id changes.
REQ-022 SHALL count BUSY cycles with a counter cleared on BUSY entry, saturating at TIMEOUT.
REQ-023 In BUSY, done[winner]=1 or req[winner]=0 SHALL move to RELEASE at that edge; done/req of other masters ignored.
REQ-024 In BUSY, counter reaching TIMEOUT without REQ-023 condition SHALL move to RELEASE and pulse timeout_err for exactly one cycle (the first RELEASE cycle).
REQ-025 If done and timeout coincide, done SHALL win; timeout_err stays 0.
REQ-026 RELEASE SHALL last exactly one cycle: grant=0, slave_sel=0, master_sel held, bus_busy=1 (turnaround); then IDLE.
REQ-027 In IDLE SHALL drive grant=0, slave_sel=0, bus_busy=0, master_sel held at last value.
REQ-028 Pending requests of non-granted masters SHALL remain pending and be arbitrated in the next IDLE cycle; one master never granted twice consecutively while another valid request is pending.
REQ-029 grant SHALL never have more than one bit set; slave_sel nonzero only while grant nonzero.

Reset
REQ-030 rstN=0 at a rising edge SHALL force IDLE, grant=0, master_sel=0, slave_sel=0, bus_busy=0, timeout_err=0, counter=0, last_granted=NO_MASTERS-1, in the following cycle.
REQ-031 Reset mid-BUSY SHALL drop grant with no RELEASE cycle and no timeout_err; first post-reset grant follows REQ-018 no earlier than one cycle after rstN=1.

Verification
REQ-032 Reset, then req=2'b01, slave_id[0]=2 -> next cycle grant=01, master_sel=0, slave_sel=2, bus_busy=1.
REQ-033 req=2'b11 held, each master pulses done 3 cycles after grant -> grants alternate 01,10,01 with one RELEASE cycle (slave_sel=0, bus_busy=1) between.
REQ-034 TIMEOUT=4, master 1 granted, never done -> RELEASE after 4 BUSY cycles, timeout_err=1 for one cycle, then IDLE.
REQ-035 req=2'b11, slave_id[0]=0, slave_id[1]=3 -> only master 1 granted, slave_sel=3; master 0 never granted.
REQ-036 rstN=0 during BUSY -> next cycle grant=0, slave_sel=0, bus_busy=0, timeout_err=0; done coincident with timeout -> timeout_err=0.
